// File: rtl/fp_reduce_ctrl.sv
// fp_reduce_ctrl: streaming IEEE-754 min/max reduction over a counted sequence of operands
module fp_reduce_ctrl #(
    parameter int BUS_WIDTH = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 op_min,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic                 in_valid,
    input  logic [BUS_WIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] result,
    output logic                 empty_err
);
    localparam int EW = (BUS_WIDTH == 64) ? 11 : 8;
    localparam int MW = BUS_WIDTH - 1 - EW;
    localparam logic [BUS_WIDTH-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] ACCUM = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           r_state;
    logic                 r_op_min;
    logic [CNT_WIDTH-1:0] r_rem;
    logic [BUS_WIDTH-1:0] r_acc;
    logic [BUS_WIDTH-1:0] r_result;
    logic                 r_empty_err;
    logic                 w_a_nan;
    logic                 w_b_nan;
    logic                 w_a_lt_b;
    logic                 w_accept;
    logic                 w_last;
    logic [BUS_WIDTH-1:0] w_cmp;
    logic [BUS_WIDTH-1:0] w_acc_next;

    assign in_ready   = (r_state == LOAD) || (r_state == ACCUM);
    assign busy       = in_ready;
    assign done       = r_state == DONE;
    assign result     = r_result;
    assign empty_err  = r_empty_err;
    assign w_accept   = in_valid && in_ready;
    assign w_last     = r_rem == CNT_WIDTH'(1);
    assign w_acc_next = (r_state == LOAD) ? in_data : w_cmp;

    // Total-order compare (sign first, then {exp,mant} magnitude, inverted for negatives) with NaN skipping
    always_comb begin
        w_a_nan  = (&r_acc[BUS_WIDTH-2:MW]) && (|r_acc[MW-1:0]);
        w_b_nan  = (&in_data[BUS_WIDTH-2:MW]) && (|in_data[MW-1:0]);
        w_a_lt_b = (r_acc[BUS_WIDTH-1] != in_data[BUS_WIDTH-1]) ? r_acc[BUS_WIDTH-1] :
                   r_acc[BUS_WIDTH-1] ? (r_acc[BUS_WIDTH-2:0] > in_data[BUS_WIDTH-2:0]) :
                                        (r_acc[BUS_WIDTH-2:0] < in_data[BUS_WIDTH-2:0]);
        w_cmp    = (w_a_nan && w_b_nan) ? QNAN :
                   w_a_nan ? in_data :
                   w_b_nan ? r_acc :
                   (w_a_lt_b ^ r_op_min) ? in_data : r_acc;
    end

    // Control FSM; result and empty_err are loaded on entry to DONE so they are valid alongside done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op_min    <= 1'b0;
            r_rem       <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_empty_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_op_min <= op_min;
                    r_rem    <= count;
                    if (count == '0) begin
                        r_result    <= QNAN;
                        r_empty_err <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                LOAD, ACCUM: if (w_accept) begin
                    r_acc <= w_acc_next;
                    r_rem <= r_rem - CNT_WIDTH'(1);
                    if (w_last) begin
                        r_result    <= w_acc_next;
                        r_empty_err <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_reduce_ctrl.sv
// tb_fp_reduce_ctrl: directed-vector bench for the min/max reduction controller
module tb_fp_reduce_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_min = 1'b0;
    logic [7:0]  count = '0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        empty_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] q[$];
    logic [63:0] res;
    logic        err;
    int          lat;
    int          nacc;
    logic        rdy_seen;
    logic        busy_ok;
    logic        done_seen;

    fp_reduce_ctrl #(.BUS_WIDTH(64), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_min(op_min), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
        .done(done), .result(result), .empty_err(empty_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues a start, feeds q under the valid pattern, waits (bounded) for done
    task automatic do_reduce(input logic op, input int cnt, input logic [15:0] vpat, input logic spam,
                             output logic [63:0] r, output logic e, output int l, output int na,
                             output logic rs, output logic bo);
        int k;
        logic acc_now;
        start = 1'b1; op_min = op; count = cnt[7:0]; in_valid = 1'b0;
        na = 0; k = 0; rs = in_ready; bo = 1'b1;
        @(posedge clk); #1;
        start = spam; l = 1;
        while (!done && l < 40) begin
            if (in_ready) rs = 1'b1;
            if (!busy) bo = 1'b0;
            in_valid = (na < q.size()) && ((k < 16) ? vpat[k] : 1'b1);
            in_data  = (na < q.size()) ? q[na] : 64'h0;
            acc_now  = in_valid && in_ready;
            @(posedge clk); #1;
            l++; k++;
            if (acc_now) na++;
        end
        if (in_ready) rs = 1'b1;
        in_valid = 1'b0;
        r = result; e = empty_err;
        chk("done_seen", {63'h0, done}, 64'h1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", {63'h0, done}, 64'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_result", result, 64'h0);
        chk("rst_empty_err", {63'h0, empty_err}, 64'h0);
        rst_n = 1'b1;

        q = '{64'h3ff0000000000000, 64'hc000000000000000, 64'h400c000000000000};
        do_reduce(1'b0, 3, 16'hffff, 1'b0, res, err, lat, nacc, rdy_seen, busy_ok);
        chk("max3_result", res, 64'h400c000000000000);
        chk("max3_err", {63'h0, err}, 64'h0);
        chk("max3_latency", 64'(lat), 64'd4);
        chk("max3_accepts", 64'(nacc), 64'd3);
        chk("max3_result_held", result, 64'h400c000000000000);

        q = '{64'h0000000000000000, 64'h8000000000000000};
        do_reduce(1'b1, 2, 16'hffff, 1'b0, res, err, lat, nacc, rdy_seen, busy_ok);
        chk("min_zeros", res, 64'h8000000000000000);
        do_reduce(1'b0, 2, 16'hffff, 1'b0, res, err, lat, nacc, rdy_seen, busy_ok);
        chk("max_zeros", res, 64'h0000000000000000);

        q = '{64'h7ff0000000000001, 64'hfff0000000000000};
        do_reduce(1'b0, 2, 16'hffff, 1'b0, res, err, lat, nacc, rdy_seen, busy_ok);
        chk("max_nan_ninf", res, 64'hfff0000000000000);
        q = '{64'h7ff0000000000001, 64'hfff0000000000002};
        do_reduce(1'b0, 2, 16'hffff, 1'b0, res, err, lat, nacc, rdy_seen, busy_ok);
        chk("max_nan_nan", res, 64'h7ff8000000000000);

        q = {};
        do_reduce(1'b0, 0, 16'hffff, 1'b0, res, err, lat, nacc, rdy_seen, busy_ok);
        chk("empty_result", res, 64'h7ff8000000000000);
        chk("empty_err", {63'h0, err}, 64'h1);
        chk("empty_latency", 64'(lat), 64'd1);
        chk("empty_no_ready", {63'h0, rdy_seen}, 64'h0);
        chk("empty_err_held", {63'h0, empty_err}, 64'h1);

        q = '{64'h0000000000000001, 64'h0000000000000003, 64'h0000000000000002, 64'h8000000000000005};
        do_reduce(1'b0, 4, 16'b0000000001011001, 1'b1, res, err, lat, nacc, rdy_seen, busy_ok);
        chk("stall_result", res, 64'h0000000000000003);
        chk("stall_accepts", 64'(nacc), 64'd4);
        chk("stall_latency", 64'(lat), 64'd8);
        chk("stall_busy", {63'h0, busy_ok}, 64'h1);
        chk("stall_err", {63'h0, err}, 64'h0);
        chk("stall_idle_after", {63'h0, busy}, 64'h0);

        start = 1'b1; op_min = 1'b0; count = 8'd5;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 64'h4014000000000000;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {63'h0, in_ready}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_done", {63'h0, done}, 64'h0);
        chk("midrst_result", result, 64'h0);
        chk("midrst_empty_err", {63'h0, empty_err}, 64'h0);
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) done_seen = 1'b1;
        end
        chk("midrst_no_done", {63'h0, done_seen}, 64'h0);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        q = '{64'hc000000000000000};
        do_reduce(1'b1, 1, 16'hffff, 1'b0, res, err, lat, nacc, rdy_seen, busy_ok);
        chk("post_rst_result", res, 64'hc000000000000000);
        chk("post_rst_latency", 64'(lat), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp_reduce_ctrl.md
FP_REDUCE_CTRL -- requirements
Module: fp_reduce_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, operand width; 64 selects double, 32 selects single; other values unsupported.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the element count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a new reduction; sampled only in IDLE.
REQ-006 SHALL have port op_min  input  1  0 = max reduction, 1 = min reduction; latched with start.
REQ-007 SHALL have port count  input  CNT_WIDTH  number of elements to reduce; latched with start.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_data  input  BUS_WIDTH  IEEE-754 operand.
REQ-010 SHALL have port in_ready  output  1  element accepted when in_valid and in_ready are both high at a rising edge.
REQ-011 SHALL have port busy  output  1  high in LOAD and ACCUM.
REQ-012 SHALL have port done  output  1  one-cycle pulse on reduction completion.
REQ-013 SHALL have port result  output  BUS_WIDTH  reduced value; held stable until the next accepted start.
REQ-014 SHALL have port empty_err  output  1  high with done when the latched count was 0; held with result.

Function
REQ-015 SHALL implement states IDLE, LOAD, ACCUM, DONE.
REQ-016 IDLE: start=1 latches op_min and count; count=0 -> DONE, else -> LOAD; start=0 -> stay.
REQ-017 LOAD: in_ready=1; on accept, acc <= in_data and remaining <= count-1; remaining=0 after accept -> DONE, else -> ACCUM.
REQ-018 ACCUM: in_ready=1; on accept, acc <= cmp(acc, in_data) and remaining decrements; the accept that makes remaining 0 -> DONE.
REQ-019 Stalls (in_valid=0) SHALL hold all state; there is no timeout.
REQ-020 DONE: lasts exactly one cycle; done=1; result <= acc, or canonical NaN if count was 0; empty_err <= (count==0); then -> IDLE.
REQ-021 Latency: done asserts on the cycle after the final accept; N elements with in_valid held high take N+1 cycles from the start cycle to done.
REQ-022 start SHALL be ignored outside IDLE; a start in the done cycle is also ignored.
REQ-023 in_ready SHALL be 0 in IDLE and DONE.
REQ-024 cmp SHALL be combinational: one compare per accepted element, with no pipeline stage.
REQ-025 cmp, if exactly one operand is NaN (exponent all-ones, mantissa nonzero) SHALL return the other operand.
REQ-026 cmp, if both operands are NaN SHALL return canonical NaN (0x7ff8000000000000 / 0x7fc00000).
REQ-027 cmp ordering SHALL be -inf < negatives < -0 < +0 < positives < +inf; max returns the larger, min returns the smaller.
REQ-028 cmp on bit-identical operands SHALL return that value.
REQ-029 Magnitude compare SHALL use {exponent, mantissa} as an unsigned integer; for two negative operands the smaller magnitude is larger.
REQ-030 Subnormals SHALL be compared exactly and not flushed.
REQ-031 result and empty_err SHALL update only in DONE.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, in_ready=0, busy=0, done=0, result=0, empty_err=0, acc=0, remaining=0, op_min=0.
REQ-033 Reset mid-reduction SHALL abandon the operation; no done SHALL follow release.
REQ-034 After rst_n release the block SHALL accept start on the first rising edge.

Verification
REQ-035 Max, BUS_WIDTH=64: count=3, elements 1.0 (0x3ff0000000000000), -2.0, 3.5 back-to-back -> done 4 cycles after start, result 0x400c000000000000, empty_err=0.
REQ-036 Min with signed zeros: count=2, elements +0 then -0 -> result 0x8000000000000000; the same stimulus with op_min=0 -> result 0x0000000000000000.
REQ-037 NaN handling: max of {NaN 0x7ff0000000000001, -inf} -> result 0xfff0000000000000; max of {NaN, NaN} -> 0x7ff8000000000000.
REQ-038 count=0 -> done one cycle after start, result 0x7ff8000000000000, empty_err=1, in_ready never high.
REQ-039 Stall and protocol: count=4 with in_valid toggling 1,0,0,1,1,0,1 -> exactly 4 accepts, busy high throughout, start pulses during busy ignored, a single done pulse.
REQ-040 Reset mid-op: rst_n low after 2 of 5 elements -> outputs at reset values at once; a new start with count=1, element 0xc000000000000000, op_min=1 -> result 0xc000000000000000.
